// File: rtl/y86_regfile_wb.sv
// Y86 register file: two combinational read ports, two clocked write-back ports
// with M-over-E priority, optional same-cycle bypass and a sequenced clear engine.
module y86_regfile_wb #(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 15,
    parameter int ADDR_W   = 4,
    parameter int RSP_IDX  = 4,
    parameter int RSP_INIT = 512,
    parameter int BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] srca_i,
    input  logic [ADDR_W-1:0] srcb_i,
    output logic [DATA_W-1:0] vala_o,
    output logic [DATA_W-1:0] valb_o,
    input  logic [ADDR_W-1:0] dste_i,
    input  logic [DATA_W-1:0] vale_i,
    input  logic [ADDR_W-1:0] dstm_i,
    input  logic [DATA_W-1:0] valm_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_done_o,
    output logic              wr_drop_o,
    output logic              dbg_state_o
);

    localparam logic [ADDR_W-1:0] NO_REG  = '1;
    localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NREGS);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(NREGS - 1);
    localparam logic [DATA_W-1:0] RSP_V   = DATA_W'(RSP_INIT);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic req_e, req_m, inr_e, inr_m, we_e, we_m;

    assign req_e = (dste_i != NO_REG);
    assign req_m = (dstm_i != NO_REG);
    assign inr_e = (dste_i < NREGS_A);
    assign inr_m = (dstm_i < NREGS_A);

    // When both ports target the same register only M is written, so E is masked.
    assign we_m = req_m && inr_m && (state_q == S_IDLE);
    assign we_e = req_e && inr_e && (state_q == S_IDLE) && !(req_m && (dste_i == dstm_i));

    assign busy_o      = (state_q == S_CLEAR);
    assign clr_done_o  = done_q;
    assign wr_drop_o   = drop_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        drop_d  = (req_e && (!inr_e || (state_q == S_CLEAR)))
               || (req_m && (!inr_m || (state_q == S_CLEAR)));
        case (state_q)
            S_IDLE: begin
                if (clr_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == LAST_A) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == RSP_IDX) ? RSP_V : '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (state_q == S_CLEAR) begin
                    if (cnt_q == ADDR_W'(i)) begin
                        regs_q[i] <= (i == RSP_IDX) ? RSP_V : '0;
                    end
                end else if (we_m && (dstm_i == ADDR_W'(i))) begin
                    regs_q[i] <= valm_i;
                end else if (we_e && (dste_i == ADDR_W'(i))) begin
                    regs_q[i] <= vale_i;
                end
            end
        end
    end

    // Bypass only forwards writes that will actually commit, so it is off during CLEAR.
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] r;
        r = '0;
        if ((idx != NO_REG) && (idx < NREGS_A)) begin
            for (int i = 0; i < NREGS; i++) begin
                if (idx == ADDR_W'(i)) r = regs_q[i];
            end
            if ((BYPASS != 0) && we_e && (dste_i == idx)) r = vale_i;
            if ((BYPASS != 0) && we_m && (dstm_i == idx)) r = valm_i;
        end
        return r;
    endfunction

    always_comb begin
        vala_o = rd(srca_i);
        valb_o = rd(srcb_i);
    end

endmodule

// File: tb/tb_y86_regfile_wb.sv
// Directed and randomized checks of y86_regfile_wb against a per-cycle register model.
module tb_y86_regfile_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  srca, srcb, dste, dstm;
    logic [63:0] vala, valb, vale, valm;
    logic        clr, busy, clr_done, wr_drop, dbg_state;

    int total = 0;
    int bad   = 0;

    logic [63:0] mregs [15];
    bit          m_busy;
    int          m_cnt;
    bit          m_done, m_drop;

    always #5 clk = ~clk;

    y86_regfile_wb dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .srca_i(srca), .srcb_i(srcb), .vala_o(vala), .valb_o(valb),
        .dste_i(dste), .vale_i(vale), .dstm_i(dstm), .valm_i(valm),
        .clr_i(clr), .busy_o(busy), .clr_done_o(clr_done), .wr_drop_o(wr_drop),
        .dbg_state_o(dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [3:0] idx);
        if (idx >= 4'd15) return 64'd0;
        if (!m_busy && dstm == idx) return valm;
        if (!m_busy && dste == idx) return vale;
        return mregs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mregs[i] = (i == 4) ? 64'd512 : 64'd0;
        m_busy = 0;
        m_cnt  = 0;
        m_done = 0;
        m_drop = 0;
    endtask

    // Effect of one rising edge given the inputs currently applied.
    task automatic model_edge();
        bit nd, ndone;
        nd    = 0;
        ndone = 0;
        if (m_busy) begin
            nd = (dste != 4'hF) || (dstm != 4'hF);
            mregs[m_cnt] = (m_cnt == 4) ? 64'd512 : 64'd0;
            if (m_cnt == 14) begin
                m_busy = 0;
                m_cnt  = 0;
                ndone  = 1;
            end else begin
                m_cnt++;
            end
        end else begin
            if (dste != 4'hF && dste != dstm) mregs[dste] = vale;
            if (dstm != 4'hF) mregs[dstm] = valm;
            if (clr) begin
                m_busy = 1;
                m_cnt  = 0;
            end
        end
        m_done = ndone;
        m_drop = nd;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, "_vala"}, vala, exp_rd(srca));
        chk({tag, "_valb"}, valb, exp_rd(srcb));
        chk({tag, "_busy"}, 64'(busy), 64'(m_busy));
        chk({tag, "_state"}, 64'(dbg_state), 64'(m_busy));
        chk({tag, "_done"}, 64'(clr_done), 64'(m_done));
        chk({tag, "_drop"}, 64'(wr_drop), 64'(m_drop));
    endtask

    task automatic set_idle();
        dste = 4'hF;
        dstm = 4'hF;
        vale = 64'd0;
        valm = 64'd0;
        clr  = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            srca = 4'(i);
            srcb = 4'(15 - i);
            check_all(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy, ndone;
        set_idle();
        srca = 4'd0;
        srcb = 4'd0;
        model_reset();
        #1 rst_n = 1'b0;
        #10;
        read_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Same-cycle bypass of a port E write, then stored value.
        dste = 4'd3; vale = 64'hAA; srca = 4'd3; srcb = 4'd4;
        check_all("byp_e");
        tick();
        set_idle();
        check_all("wr_e");

        // Both ports on one register: M wins, no drop.
        dste = 4'd5; dstm = 4'd5; vale = 64'h11; valm = 64'h22; srca = 4'd5; srcb = 4'd5;
        check_all("byp_em");
        tick();
        set_idle();
        check_all("em_prio");

        // Fill r1..r14, then run a full clear with a write attempted mid-sequence.
        for (int i = 1; i < 15; i += 2) begin
            dste = 4'(i); dstm = 4'(i + 1); vale = 64'hFF; valm = 64'hFF;
            tick();
        end
        set_idle();
        read_all("filled");
        clr = 1'b1; dste = 4'd6; vale = {$urandom(), $urandom()}; srca = 4'd6;
        check_all("clr_acc");
        tick();
        set_idle();
        nbusy = 0;
        for (int c = 0; c < 15; c++) begin
            srca = 4'($urandom_range(0, 15));
            srcb = 4'($urandom_range(0, 15));
            if (c == 3) begin dste = 4'd2; vale = 64'h123; end
            else dste = 4'hF;
            check_all("clr_run");
            if (busy) nbusy++;
            tick();
        end
        set_idle();
        check_all("clr_end");
        chk("busy_len", 64'(nbusy), 64'd15);
        tick();
        read_all("after_clr");

        // Asynchronous reset in the middle of a clear.
        for (int i = 0; i < 15; i++) begin
            dste = 4'(i); vale = {$urandom(), $urandom()};
            tick();
        end
        set_idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            srca = 4'($urandom_range(0, 14));
            check_all("clr_mid");
            tick();
        end
        #2 rst_n = 1'b0;
        model_reset();
        read_all("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst");

        // Extra clear requests while busy are ignored.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            clr = (c == 2 || c == 7);
            srca = 4'($urandom_range(0, 15));
            check_all("clr_twice");
            if (clr_done) ndone++;
            tick();
        end
        set_idle();
        check_all("clr_twice_end");
        chk("single_done", 64'(ndone), 64'd1);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            dste = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            dstm = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            if ($urandom_range(0, 7) == 0) dstm = dste;
            vale = {$urandom(), $urandom()};
            valm = {$urandom(), $urandom()};
            clr  = ($urandom_range(0, 49) == 0);
            srca = ($urandom_range(0, 2) == 0) ? dste : 4'($urandom_range(0, 15));
            srcb = ($urandom_range(0, 2) == 0) ? dstm : 4'($urandom_range(0, 15));
            check_all("rand");
            tick();
        end
        set_idle();
        read_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/y86_regfile_wb.md
Name: y86_regfile_wb

Overview:
Parametrised Y86 register file with two combinational read ports (srcA/srcB) and two clocked write-back ports (dstE/dstM). It replaces the read-only register array currently embedded in decode. It adds write-back, same-cycle bypass and an M-over-E write priority. It also adds a sequenced, multi-cycle clear engine with busy/done signalling. It sits between fetch/decode (reads) and the execute/memory write-back path (writes).

Parameters:
DATA_W, 64, register data width in bits.
NREGS, 15, number of architectural registers (index 0..NREGS-1); must be <= 15.
ADDR_W, 4, register index width; all-ones (4'hF) means "no register".
RSP_IDX, 4, index of the stack pointer register.
RSP_INIT, 512, value loaded into RSP_IDX by reset and by the clear engine.
BYPASS, 1, 1 = a read returns the same-cycle write data for a matching index; 0 = a read returns stored contents only.

Ports:
clk_i  input  1  clock, all state updates on rising edge.
rst_n_i  input  1  asynchronous active-low reset.
srca_i  input  ADDR_W  read port A index.
srcb_i  input  ADDR_W  read port B index.
vala_o  output  DATA_W  read port A data.
valb_o  output  DATA_W  read port B data.
dste_i  input  ADDR_W  write port E index (4'hF = no write).
vale_i  input  DATA_W  write port E data.
dstm_i  input  ADDR_W  write port M index (4'hF = no write).
valm_i  input  DATA_W  write port M data.
clr_i  input  1  clear request, sampled on clock edge.
busy_o  output  1  clear engine active.
clr_done_o  output  1  one-cycle pulse when the clear sequence completes.
wr_drop_o  output  1  one-cycle pulse when any requested write was discarded.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - All registers go to 0, except RSP_IDX, which goes to RSP_INIT.
  - FSM goes to IDLE, clear counter to 0.
  - busy_o, clr_done_o and wr_drop_o go to 0.
  - Read outputs follow the combinational rules below using the reset contents.
- Reads are combinational with 0 cycles latency:
  - Index 4'hF, or any index >= NREGS, returns 0.
  - With BYPASS=1, if the index matches a valid write port this cycle, the write data is returned. dstM takes priority over dstE.
  - With BYPASS=0, stored contents are returned.
- Writes commit on the rising edge, visible next cycle (BYPASS=0), when all of the following hold:
  - the index is not 4'hF;
  - the index is < NREGS;
  - FSM is IDLE.
- If dste_i == dstm_i (valid), only valm_i is written; this is not a drop.
- A write to index >= NREGS (not 4'hF) is discarded and pulses wr_drop_o in the next cycle.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR when clr_i = 1 on an edge. The counter is set to 0 and busy_o = 1 from the next cycle.
  - In CLEAR, each edge writes register[counter] := 0 (RSP_INIT if counter == RSP_IDX), then increments the counter.
  - When the counter == NREGS-1 is written: return to IDLE, busy_o = 0, clr_done_o = 1 for exactly one cycle.
  - A full clear takes NREGS cycles.
- Writes requested while in CLEAR (including the cycle clr_i is accepted in IDLE):
  - Writes in the accept cycle commit normally.
  - Writes in CLEAR cycles are discarded and pulse wr_drop_o.
- clr_i while busy is ignored; there is no restart or queueing.
- Reads during CLEAR return current stored contents: cleared registers read 0, uncleared ones read their old value. Bypass is disabled in CLEAR.
- Reset asserted mid-clear: immediate return to the reset state; no clr_done_o pulse.
- Arithmetic: counter width is ADDR_W with no wrap beyond NREGS-1. Data is stored unmodified at DATA_W bits.

Test Plan:
1. Reset then read all indices -> r4 = 512, r0..r3 and r5..r14 = 0, index 4'hF = 0, busy_o = 0.
2. dste = 3 / vale = 0xAA, and a read of srca = 3 in the same cycle -> vala = 0xAA combinationally (BYPASS=1). With BYPASS=0: vala = 0 that cycle and 0xAA the next cycle.
3. dste = dstm = 5, vale = 0x11, valm = 0x22 -> next cycle r5 = 0x22, wr_drop_o = 0. Same-cycle bypass read of 5 = 0x22.
4. Write r1..r14 = 0xFF, pulse clr_i -> busy_o high for 15 cycles.
   - A dste = 2 write during busy is dropped and wr_drop_o pulses.
   - clr_done_o pulses once.
   - Afterwards all registers = 0 except r4 = 512.
5. Pulse clr_i, deassert rst_n_i asynchronously after 6 cycles of CLEAR -> busy_o = 0 immediately, no clr_done_o pulse, registers at reset values.
6. Pulse clr_i twice during busy -> single 15-cycle sequence, a single clr_done_o pulse.
